tm_class_vote_argmax: RTL and testbench

//  Downstream stage of Tsetlin Machine inference. Consumes per-class clause-output words, one class per

---
 rtl/tm_pkg.sv | 19 +
 rtl/tm_class_vote_argmax_if.sv | 28 ++
 rtl/tm_polarity_popcount.sv | 28 ++
 rtl/tm_class_vote_argmax.sv | 124 ++++++++++++
 tb/tb_tm_class_vote_argmax.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tm_pkg.sv
// Shared definitions for the Tsetlin Machine inference stages.
// Holds the frame geometry (classes per frame, clauses per class), the derived
// widths of the class index and signed class sum, and the verdict FSM states.
package tm_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int NUM_CLAUSES = 100;
    localparam int CLASS_W     = $clog2(NUM_CLASSES);
    // Unsigned count of one polarity half; the signed sum adds one sign bit.
    localparam int CNT_W       = $clog2(NUM_CLAUSES / 2 + 1);
    localparam int SUM_W       = CNT_W + 1;

    typedef enum logic [1:0] {
        ACCEPT,
        DRAIN,
        HOLD
    } state_t;

endpackage

// File: rtl/tm_class_vote_argmax_if.sv
// Handshake bundle of the class-vote / argmax stage.
//   clause_valid/clause_ready/clause_bits   : one class word per beat, upstream -> stage
//   verdict_valid/verdict_ready             : verdict handshake, stage -> consumer
//   verdict_class/verdict_score             : winning class index and its signed sum
// Modports: master = producer/consumer side (bench or neighbouring stages),
//           slave  = the argmax stage itself.
interface tm_class_vote_argmax_if;
    import tm_pkg::*;

    logic                       clause_valid;
    logic                       clause_ready;
    logic [NUM_CLAUSES-1:0]     clause_bits;
    logic                       verdict_valid;
    logic                       verdict_ready;
    logic [CLASS_W-1:0]         verdict_class;
    logic signed [SUM_W-1:0]    verdict_score;

    modport master (
        output clause_valid, clause_bits, verdict_ready,
        input  clause_ready, verdict_valid, verdict_class, verdict_score
    );

    modport slave (
        input  clause_valid, clause_bits, verdict_ready,
        output clause_ready, verdict_valid, verdict_class, verdict_score
    );

endinterface

// File: rtl/tm_polarity_popcount.sv
// Combinational class-sum: counts the set clause outputs of each polarity and
// returns (#even set) - (#odd set) as a signed value.
//   clause_bits : in  NUM_CLAUSES  clause outputs of one class (even idx = +, odd idx = -)
//   diff        : out SUM_W        signed class sum, range +/-NUM_CLAUSES/2
module tm_polarity_popcount
    import tm_pkg::*;
(
    input  logic [NUM_CLAUSES-1:0]  clause_bits,
    output logic signed [SUM_W-1:0] diff
);

    logic [CNT_W-1:0] pos_cnt;
    logic [CNT_W-1:0] neg_cnt;

    // Two independent accumulations over the polarity halves; synthesis balances
    // each chain into an adder tree.
    always_comb begin
        pos_cnt = '0;
        neg_cnt = '0;
        for (int unsigned i = 0; i < NUM_CLAUSES / 2; i++) begin
            pos_cnt = pos_cnt + CNT_W'(clause_bits[2*i]);
            neg_cnt = neg_cnt + CNT_W'(clause_bits[2*i+1]);
        end
        // Zero-extending both counts by one bit makes the subtraction exact in SUM_W.
        diff = $signed({1'b0, pos_cnt}) - $signed({1'b0, neg_cnt});
    end

endmodule

// File: rtl/tm_class_vote_argmax.sv
// Class vote and running argmax for Tsetlin Machine inference.
// Takes one class word per accepted beat (classes 0..NUM_CLASSES-1 in order),
// forms the signed class sum in stage 1, keeps the best (strictly greater wins,
// so ties keep the lower index) in stage 2, and presents the frame verdict
// until the consumer takes it.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   flush : synchronous frame abort, highest priority
//   bus   : clause input and verdict output handshakes (slave side)
module tm_class_vote_argmax
    import tm_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    tm_class_vote_argmax_if.slave     bus
);

    state_t                  state;
    logic [CLASS_W-1:0]      cls_cnt;
    logic                    clause_ready_q;

    logic                    s1_valid;
    logic                    s1_last;
    logic [CLASS_W-1:0]      s1_class;
    logic signed [SUM_W-1:0] s1_diff;

    logic                    s2_done;
    logic [CLASS_W-1:0]      best_class;
    logic signed [SUM_W-1:0] best_score;

    logic                    verdict_valid_q;
    logic [CLASS_W-1:0]      verdict_class_q;
    logic signed [SUM_W-1:0] verdict_score_q;

    logic                    accept;
    logic                    last_class;
    logic signed [SUM_W-1:0] diff;

    assign accept     = bus.clause_valid & clause_ready_q;
    assign last_class = (cls_cnt == CLASS_W'(NUM_CLASSES - 1));

    tm_polarity_popcount u_popcount (
        .clause_bits (bus.clause_bits),
        .diff        (diff)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ACCEPT;
            cls_cnt         <= '0;
            clause_ready_q  <= 1'b0;
            s1_valid        <= 1'b0;
            s1_last         <= 1'b0;
            s1_class        <= '0;
            s1_diff         <= '0;
            s2_done         <= 1'b0;
            best_class      <= '0;
            best_score      <= '0;
            verdict_valid_q <= 1'b0;
            verdict_class_q <= '0;
            verdict_score_q <= '0;
        end else if (flush) begin
            state           <= ACCEPT;
            cls_cnt         <= '0;
            clause_ready_q  <= 1'b1;
            s1_valid        <= 1'b0;
            s2_done         <= 1'b0;
            best_class      <= '0;
            best_score      <= '0;
            verdict_valid_q <= 1'b0;
        end else begin
            // Stage 1: class sum, index and last flag of the accepted word.
            s1_valid <= accept;
            if (accept) begin
                s1_class <= cls_cnt;
                s1_diff  <= diff;
                s1_last  <= last_class;
                cls_cnt  <= last_class ? '0 : cls_cnt + 1'b1;
            end

            // Stage 2: running argmax; class 0 seeds the frame.
            s2_done <= s1_valid & s1_last;
            if (s1_valid && ((s1_class == '0) || (s1_diff > best_score))) begin
                best_class <= s1_class;
                best_score <= s1_diff;
            end

            case (state)
                ACCEPT: begin
                    clause_ready_q <= 1'b1;
                    if (accept && last_class) begin
                        clause_ready_q <= 1'b0;
                        state          <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (s2_done) begin
                        verdict_valid_q <= 1'b1;
                        verdict_class_q <= best_class;
                        verdict_score_q <= best_score;
                        state           <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.verdict_ready) begin
                        verdict_valid_q <= 1'b0;
                        best_class      <= '0;
                        best_score      <= '0;
                        clause_ready_q  <= 1'b1;
                        state           <= ACCEPT;
                    end
                end
                default: state <= ACCEPT;
            endcase
        end
    end

    assign bus.clause_ready  = clause_ready_q;
    assign bus.verdict_valid = verdict_valid_q;
    assign bus.verdict_class = verdict_class_q;
    assign bus.verdict_score = verdict_score_q;

endmodule

// File: tb/tb_tm_class_vote_argmax.sv
// Self-checking bench for tm_class_vote_argmax: directed frames, back-pressure,
// flush, mid-frame reset and random frames, each checked against an argmax
// reference computed from per-class vote counts.
`timescale 1ns/1ps
module tb_tm_class_vote_argmax;
    import tm_pkg::*;

    logic clk;
    logic rst_n;
    logic flush;

    tm_class_vote_argmax_if bus ();

    tm_class_vote_argmax dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  errors = 0;
    int  checks = 0;
    time last_acc_t = 0;
    logic [NUM_CLAUSES-1:0] frm [NUM_CLASSES];

    // ---------------- reference model ----------------
    function automatic int score_of(input logic [NUM_CLAUSES-1:0] w);
        int s = 0;
        for (int i = 0; i < NUM_CLAUSES; i++)
            if (w[i]) s += ((i % 2) == 0) ? 1 : -1;
        return s;
    endfunction

    task automatic model_argmax(output int cls, output int sc);
        int scores [NUM_CLASSES];
        int mx;
        for (int c = 0; c < NUM_CLASSES; c++) scores[c] = score_of(frm[c]);
        mx = scores[0];
        for (int c = 1; c < NUM_CLASSES; c++) if (scores[c] > mx) mx = scores[c];
        cls = -1;
        for (int c = NUM_CLASSES - 1; c >= 0; c--) if (scores[c] == mx) cls = c;
        sc = mx;
    endtask

    function automatic logic [NUM_CLAUSES-1:0] even_n(input int n);
        logic [NUM_CLAUSES-1:0] w = '0;
        for (int i = 0; i < n; i++) w[2*i] = 1'b1;
        return w;
    endfunction

    function automatic logic [NUM_CLAUSES-1:0] odd_all();
        logic [NUM_CLAUSES-1:0] w = '0;
        for (int i = 0; i < NUM_CLAUSES / 2; i++) w[2*i+1] = 1'b1;
        return w;
    endfunction

    function automatic logic [NUM_CLAUSES-1:0] rand_word();
        logic [127:0] r;
        logic [127:0] m;
        r = {$urandom, $urandom, $urandom, $urandom};
        m = {$urandom, $urandom, $urandom, $urandom};
        // Sparse masking now and then to spread the class sums.
        if ($urandom_range(0, 1) == 1) r = r & m;
        return r[NUM_CLAUSES-1:0];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send_word(input logic [NUM_CLAUSES-1:0] w);
        int unsigned gap;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            @(negedge clk);
            bus.clause_valid = 1'b0;
        end
        @(negedge clk);
        bus.clause_valid = 1'b1;
        bus.clause_bits  = w;
        checks++;
        for (int t = 0; t < 40; t++) begin
            if (bus.clause_ready === 1'b1) begin
                @(posedge clk);
                last_acc_t = $time;
                return;
            end
            @(negedge clk);
        end
        errors++;
        $display("FAIL accept_timeout: clause_ready=%b after 40 cycles, required 1", bus.clause_ready);
    endtask

    task automatic send_frame(input bit preloaded);
        for (int c = 0; c < NUM_CLASSES; c++) begin
            if (c == 0 && preloaded) begin
                @(posedge clk);
                last_acc_t = $time;
            end else begin
                send_word(frm[c]);
            end
        end
    endtask

    // Waits for the verdict, checks latency/content, holds it for `hold` cycles
    // (optionally presenting the next frame's first word), then hands it off.
    task automatic check_verdict(input int exp_cls, input int exp_sc, input int hold,
                                 input bit preload, input logic [NUM_CLAUSES-1:0] nextw);
        bit  seen = 0;
        int  lat;
        logic [CLASS_W-1:0]      ec = CLASS_W'(exp_cls);
        logic signed [SUM_W-1:0] es = SUM_W'(exp_sc);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (t == 0) bus.clause_valid = 1'b0;
            if (bus.verdict_valid === 1'b1) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL verdict_timeout: verdict_valid=%b, required 1 within 20 cycles", bus.verdict_valid);
            return;
        end
        lat = int'(($time - last_acc_t - 5) / 10);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL verdict_latency: got %0d cycles, required 2", lat);
        end
        checks++;
        if (bus.verdict_class !== ec) begin
            errors++;
            $display("FAIL verdict_class: got %0d, required %0d", bus.verdict_class, ec);
        end
        checks++;
        if (bus.verdict_score !== es) begin
            errors++;
            $display("FAIL verdict_score: got %0d, required %0d", bus.verdict_score, es);
        end
        checks++;
        if (bus.clause_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_hold: clause_ready=%b, required 0", bus.clause_ready);
        end
        if (preload) begin
            bus.clause_valid = 1'b1;
            bus.clause_bits  = nextw;
        end
        for (int d = 0; d < hold; d++) begin
            @(negedge clk);
            checks++;
            if (bus.verdict_valid !== 1'b1 || bus.verdict_class !== ec ||
                bus.verdict_score !== es || bus.clause_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: valid=%b class=%0d score=%0d ready=%b, required 1/%0d/%0d/0",
                         bus.verdict_valid, bus.verdict_class, bus.verdict_score,
                         bus.clause_ready, ec, es);
            end
        end
        bus.verdict_ready = 1'b1;
        @(negedge clk);
        bus.verdict_ready = 1'b0;
        checks++;
        if (bus.verdict_valid !== 1'b0 || bus.clause_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake: verdict_valid=%b clause_ready=%b, required 0/1",
                     bus.verdict_valid, bus.clause_ready);
        end
    endtask

    task automatic run_frame(input int hold);
        int c, s;
        model_argmax(c, s);
        send_frame(1'b0);
        check_verdict(c, s, hold, 1'b0, '0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.clause_ready !== 1'b0 || bus.verdict_valid !== 1'b0 ||
            bus.verdict_class !== '0 || bus.verdict_score !== '0) begin
            errors++;
            $display("FAIL reset_values: ready=%b valid=%b class=%0d score=%0d, required all 0",
                     bus.clause_ready, bus.verdict_valid, bus.verdict_class, bus.verdict_score);
        end
        rst_n = 1'b1;
        checks++;
        if (bus.clause_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_at_release: got %b, required 0", bus.clause_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.clause_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got %b, required 1", bus.clause_ready);
        end
    endtask

    task automatic test_single_hot();
        for (int c = 0; c < NUM_CLASSES; c++) frm[c] = '0;
        frm[7] = even_n(NUM_CLAUSES / 2);
        check_verdict_direct(7, 50, 0);
    endtask

    task automatic test_tie();
        for (int c = 0; c < NUM_CLASSES; c++) frm[c] = '0;
        frm[2] = even_n(3);
        frm[5] = even_n(3);
        check_verdict_direct(2, 3, 1);
    endtask

    task automatic test_negative();
        logic [NUM_CLAUSES-1:0] w;
        for (int c = 0; c < NUM_CLASSES; c++) frm[c] = odd_all();
        w = odd_all();
        w[17] = 1'b0;
        frm[9] = w;
        check_verdict_direct(9, -49, 0);
    endtask

    // Directed frame: cross-check the model against the hand-derived verdict too.
    task automatic check_verdict_direct(input int exp_cls, input int exp_sc, input int hold);
        int c, s;
        model_argmax(c, s);
        checks++;
        if (c != exp_cls || s != exp_sc) begin
            errors++;
            $display("FAIL model_directed: model %0d/%0d, required %0d/%0d", c, s, exp_cls, exp_sc);
        end
        send_frame(1'b0);
        check_verdict(exp_cls, exp_sc, hold, 1'b0, '0);
    endtask

    task automatic test_back_to_back_backpressure();
        int c, s;
        for (int k = 0; k < NUM_CLASSES; k++) frm[k] = rand_word();
        model_argmax(c, s);
        send_frame(1'b0);
        for (int k = 0; k < NUM_CLASSES; k++) frm[k] = rand_word();
        check_verdict(c, s, 5, 1'b1, frm[0]);
        model_argmax(c, s);
        send_frame(1'b1);
        check_verdict(c, s, 0, 1'b0, '0);
    endtask

    task automatic test_flush();
        for (int k = 0; k < 4; k++) send_word(rand_word());
        @(negedge clk);
        flush = 1'b1;
        bus.clause_valid = 1'b1;
        bus.clause_bits  = even_n(NUM_CLAUSES / 2);
        @(negedge clk);
        flush = 1'b0;
        bus.clause_valid = 1'b0;
        checks++;
        if (bus.clause_ready !== 1'b1 || bus.verdict_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: ready=%b valid=%b, required 1/0", bus.clause_ready, bus.verdict_valid);
        end
        for (int k = 0; k < NUM_CLASSES; k++) frm[k] = '0;
        frm[4] = even_n(10);
        check_verdict_direct(4, 10, 0);
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 0; k < 6; k++) send_word(rand_word());
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.clause_ready !== 1'b0 || bus.verdict_valid !== 1'b0 ||
            bus.verdict_class !== '0 || bus.verdict_score !== '0) begin
            errors++;
            $display("FAIL midframe_reset: ready=%b valid=%b class=%0d score=%0d, required all 0",
                     bus.clause_ready, bus.verdict_valid, bus.verdict_class, bus.verdict_score);
        end
        @(negedge clk);
        bus.clause_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.clause_ready !== 1'b1 || bus.verdict_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: ready=%b valid=%b, required 1/0", bus.clause_ready, bus.verdict_valid);
        end
        for (int k = 0; k < NUM_CLASSES; k++) frm[k] = rand_word();
        run_frame(0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < NUM_CLASSES; k++) frm[k] = rand_word();
            // Force a tie on some frames to exercise the lower-index rule.
            if (f % 2 == 1) frm[NUM_CLASSES - 1] = frm[$urandom_range(0, NUM_CLASSES - 2)];
            run_frame(int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        flush             = 1'b0;
        bus.clause_valid  = 1'b0;
        bus.clause_bits   = '0;
        bus.verdict_ready = 1'b0;

        test_reset();
        test_single_hot();
        test_tie();
        test_negative();
        test_back_to_back_backpressure();
        test_flush();
        test_reset_mid_frame();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
